// File: rtl/mf_pll_recfg_pkg.sv
// Shared types, register map and frequency preset table for the PLL reconfiguration controller.
// Used by mf_pll_recfg_if, mf_pll_recfg_sync and mf_pll_recfg_ctrl.
package mf_pll_recfg_pkg;

    localparam int NUM_PRESETS = 4;
    localparam int PRESET_AW   = $clog2(NUM_PRESETS);
    // One extra index bit so requests past the end of the table can be seen and rejected.
    localparam int PRESET_IW   = PRESET_AW + 1;
    localparam int TMO_W       = 17;

    localparam logic [PRESET_IW-1:0] NUM_PRESETS_IW = PRESET_IW'(NUM_PRESETS);

    localparam logic [5:0] ADDR_MODE  = 6'h00;
    localparam logic [5:0] ADDR_START = 6'h02;
    localparam logic [5:0] ADDR_N     = 6'h03;
    localparam logic [5:0] ADDR_M     = 6'h04;
    localparam logic [5:0] ADDR_C     = 6'h05;
    localparam logic [5:0] ADDR_K     = 6'h07;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_MODE,
        ST_WR_N,
        ST_WR_M,
        ST_WR_C0,
        ST_WR_K,
        ST_START,
        ST_WAIT_LOCK,
        ST_FIN
    } state_t;

    typedef struct packed {
        logic       odd;
        logic       bypass;
        logic [7:0] hi;
        logic [7:0] lo;
    } pll_cnt_t;

    typedef struct packed {
        pll_cnt_t    n;
        pll_cnt_t    m;
        pll_cnt_t    c0;
        logic [31:0] k;
    } pll_cfg_t;

    // Counter word layout; bits [22:18] stay zero, which selects counter C0 for the C write.
    function automatic logic [31:0] cnt_word(input pll_cnt_t c);
        return {14'd0, c};
    endfunction

    localparam pll_cfg_t PLL_PRESETS [NUM_PRESETS] = '{
        '{'{1'b0, 1'b1, 8'd0,  8'd0},  '{1'b1, 1'b0, 8'd6,  8'd5},
          '{1'b1, 1'b0, 8'd3,  8'd2},  32'd1055665304},
        '{'{1'b0, 1'b1, 8'd0,  8'd0},  '{1'b0, 1'b0, 8'd8,  8'd8},
          '{1'b0, 1'b0, 8'd4,  8'd4},  32'h0000_0000},
        '{'{1'b0, 1'b0, 8'd1,  8'd1},  '{1'b1, 1'b0, 8'd12, 8'd11},
          '{1'b0, 1'b0, 8'd5,  8'd5},  32'h8000_0000},
        '{'{1'b0, 1'b1, 8'd0,  8'd0},  '{1'b0, 1'b0, 8'd10, 8'd10},
          '{1'b1, 1'b0, 8'd2,  8'd1},  32'h4000_0000}
    };

endpackage

// File: rtl/mf_pll_recfg_if.sv
// Request/status handshake plus the Avalon-MM management bus toward altera_pll_reconfig.
// master = the reconfiguration controller, slave = requester and reconfig IP side.
interface mf_pll_recfg_if;
    import mf_pll_recfg_pkg::*;

    logic                 req_valid;
    logic [PRESET_IW-1:0] req_preset;
    logic                 req_ready;
    logic                 done;
    logic                 err;
    logic                 busy;
    logic [5:0]           mgmt_address;
    logic                 mgmt_write;
    logic [31:0]          mgmt_writedata;
    logic                 mgmt_waitrequest;

    modport master (
        input  req_valid, req_preset, mgmt_waitrequest,
        output req_ready, done, err, busy, mgmt_address, mgmt_write, mgmt_writedata
    );

    modport slave (
        output req_valid, req_preset, mgmt_waitrequest,
        input  req_ready, done, err, busy, mgmt_address, mgmt_write, mgmt_writedata
    );

endinterface

// File: rtl/mf_pll_recfg_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock indication into the management clock domain.
module mf_pll_recfg_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/mf_pll_recfg_ctrl.sv
// Sequences MODE/N/M/C0/K/START writes to the PLL reconfig IP for a chosen preset, then waits for lock.
// Optional lock timeout enabled by defining MF_PLL_RECFG_LOCK_TIMEOUT_EN.
module mf_pll_recfg_ctrl
    import mf_pll_recfg_pkg::*;
`ifdef MF_PLL_RECFG_LOCK_TIMEOUT_EN
#(
    parameter int unsigned LOCK_TIMEOUT = 100000
)
`endif
(
    input  logic           clk,
    input  logic           rst,
    input  logic           pll_locked,
    mf_pll_recfg_if.master bus
);

    state_t               state_q, state_d;
    state_t               wr_next;
    logic                 phase_q, phase_d;
    logic [PRESET_AW-1:0] sel_q, sel_d;
    logic                 err_q, err_d;
    logic [2:0]           lock_cnt_q, lock_cnt_d;
    logic                 lock_s;
    logic                 is_wr;
    logic [5:0]           wr_addr;
    logic [31:0]          wr_data;
    pll_cfg_t             cfg;

`ifdef MF_PLL_RECFG_LOCK_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    mf_pll_recfg_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (pll_locked),
        .sync_out (lock_s)
    );

    assign cfg = PLL_PRESETS[sel_q];

    // Each write state spends one cycle with write low (phase 0), then holds write until accepted.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        sel_d      = sel_q;
        err_d      = err_q;
        lock_cnt_d = lock_cnt_q;
        wr_next    = ST_IDLE;
        is_wr      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
`ifdef MF_PLL_RECFG_LOCK_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                err_d = 1'b0;
                if (bus.req_valid) begin
                    if (bus.req_preset < NUM_PRESETS_IW) begin
                        sel_d   = bus.req_preset[PRESET_AW-1:0];
                        state_d = ST_MODE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end
                end
            end
            ST_MODE: begin
                is_wr   = 1'b1;
                wr_addr = ADDR_MODE;
                wr_next = ST_WR_N;
            end
            ST_WR_N: begin
                is_wr   = 1'b1;
                wr_addr = ADDR_N;
                wr_data = cnt_word(cfg.n);
                wr_next = ST_WR_M;
            end
            ST_WR_M: begin
                is_wr   = 1'b1;
                wr_addr = ADDR_M;
                wr_data = cnt_word(cfg.m);
                wr_next = ST_WR_C0;
            end
            ST_WR_C0: begin
                is_wr   = 1'b1;
                wr_addr = ADDR_C;
                wr_data = cnt_word(cfg.c0);
                wr_next = ST_WR_K;
            end
            ST_WR_K: begin
                is_wr   = 1'b1;
                wr_addr = ADDR_K;
                wr_data = cfg.k;
                wr_next = ST_START;
            end
            ST_START: begin
                is_wr      = 1'b1;
                wr_addr    = ADDR_START;
                wr_data    = 32'd1;
                wr_next    = ST_WAIT_LOCK;
                lock_cnt_d = '0;
`ifdef MF_PLL_RECFG_LOCK_TIMEOUT_EN
                tmo_cnt_d  = '0;
`endif
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    lock_cnt_d = lock_cnt_q + 3'd1;
                    if (lock_cnt_q == 3'd7) begin
                        state_d = ST_FIN;
                    end
                end else begin
                    lock_cnt_d = '0;
                end
`ifdef MF_PLL_RECFG_LOCK_TIMEOUT_EN
                // A lock that completes on the final timeout cycle still counts as success.
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (state_d != ST_FIN && tmo_cnt_q == TMO_LAST) begin
                    state_d = ST_FIN;
                    err_d   = 1'b1;
                end
`endif
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (is_wr) begin
            if (!phase_q) begin
                phase_d = 1'b1;
            end else if (!bus.mgmt_waitrequest) begin
                phase_d = 1'b0;
                state_d = wr_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= 1'b0;
            sel_q      <= '0;
            err_q      <= 1'b0;
            lock_cnt_q <= '0;
`ifdef MF_PLL_RECFG_LOCK_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            sel_q      <= sel_d;
            err_q      <= err_d;
            lock_cnt_q <= lock_cnt_d;
`ifdef MF_PLL_RECFG_LOCK_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
`endif
        end
    end

    assign bus.mgmt_write     = is_wr & phase_q;
    assign bus.mgmt_address   = wr_addr;
    assign bus.mgmt_writedata = wr_data;
    assign bus.req_ready      = (state_q == ST_IDLE);
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.done           = (state_q == ST_FIN);
    assign bus.err            = (state_q == ST_FIN) & err_q;

endmodule

// File: tb/tb_mf_pll_recfg_ctrl.sv
// Self-checking bench for mf_pll_recfg_ctrl: vector table of requests plus reset, timeout and glitch sequences.
// Build with MF_PLL_RECFG_LOCK_TIMEOUT_EN to exercise the lock timeout path.
module tb_mf_pll_recfg_ctrl;
    import mf_pll_recfg_pkg::*;

    typedef struct {
        int         preset;
        logic [5:0] stall_addr;
        int         stall_n;
        int         lock_delay;
        bit         glitch;
        bit         exp_err;
        int         exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic pll_locked;
    int   cyc = 0;

    int   n_checks = 0;
    int   n_pass   = 0;

    logic [37:0] exp_q[$];
    logic [31:0] exp_words [4][4];
    vec_t        vecs [8];
    vec_t        vec_after_rst;

    logic [5:0]  stall_addr = 6'h3F;
    int          stall_left = 0;
    bit          start_seen = 1'b0;
    int          start_cyc  = 0;
    int          accept_cyc = 0;
    int          lat0       = 0;
    int          lat1       = 0;

    mf_pll_recfg_if bus ();

`ifdef MF_PLL_RECFG_LOCK_TIMEOUT_EN
    localparam int TB_TIMEOUT = 100;
    mf_pll_recfg_ctrl #(.LOCK_TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .bus(bus)
    );
`else
    mf_pll_recfg_ctrl dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .bus(bus)
    );
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reconfig IP model: optional waitrequest stall, write retirement into the scoreboard.
    initial begin : slave_model
        logic       prev_stall;
        logic       prev_retire;
        logic       wr_wait;
        logic [5:0] prev_addr;
        logic [31:0] prev_data;
        logic [37:0] e;
        prev_stall  = 1'b0;
        prev_retire = 1'b0;
        prev_addr   = '0;
        prev_data   = '0;
        bus.mgmt_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_stall  = 1'b0;
                prev_retire = 1'b0;
                bus.mgmt_waitrequest = 1'b0;
            end else begin
                if (prev_stall) begin
                    checkOutput("stall_addr_hold", 64'(bus.mgmt_address), 64'(prev_addr));
                    checkOutput("stall_data_hold", 64'(bus.mgmt_writedata), 64'(prev_data));
                    checkOutput("stall_write_hold", 64'(bus.mgmt_write), 64'd1);
                end
                if (prev_retire) checkOutput("write_gap", 64'(bus.mgmt_write), 64'd0);
                wr_wait = bus.mgmt_write && (bus.mgmt_address == stall_addr) && (stall_left > 0);
                if (wr_wait) stall_left--;
                bus.mgmt_waitrequest = wr_wait;
                prev_stall  = wr_wait;
                prev_addr   = bus.mgmt_address;
                prev_data   = bus.mgmt_writedata;
                prev_retire = bus.mgmt_write && !wr_wait;
                if (prev_retire) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                                 bus.mgmt_address, bus.mgmt_writedata);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("write_addr_data", 64'({bus.mgmt_address, bus.mgmt_writedata}), 64'(e));
                    end
                    if (bus.mgmt_address == ADDR_START) begin
                        start_seen = 1'b1;
                        start_cyc  = cyc;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input int preset);
        pll_locked = 1'b0;
        start_seen = 1'b0;
        if (preset < 4) begin
            exp_q.push_back({ADDR_MODE, 32'd0});
            exp_q.push_back({ADDR_N, exp_words[preset][0]});
            exp_q.push_back({ADDR_M, exp_words[preset][1]});
            exp_q.push_back({ADDR_C, exp_words[preset][2]});
            exp_q.push_back({ADDR_K, exp_words[preset][3]});
            exp_q.push_back({ADDR_START, 32'd1});
        end
        for (int i = 0; i < 50 && !bus.req_ready; i++) tick();
        checkOutput("ready_before_req", 64'(bus.req_ready), 64'd1);
        bus.req_valid  = 1'b1;
        bus.req_preset = PRESET_IW'(preset);
        tick();
        bus.req_valid  = 1'b0;
        accept_cyc     = cyc;
    endtask

    task automatic driveLock(input int d, input bit glitch);
        for (int i = 0; i < 300 && !start_seen; i++) tick();
        if (!start_seen) begin
            n_checks++;
            $display("[TB] FAIL start_write: got none within 300 cycles, required a START write");
        end else begin
            while (cyc < start_cyc + d) tick();
            pll_locked = 1'b1;
            if (glitch) begin
                tick(); tick(); tick();
                pll_locked = 1'b0;
                tick();
                pll_locked = 1'b1;
            end
        end
    endtask

    task automatic waitDone(input int bound, output int dcyc, output logic derr);
        dcyc = -1;
        derr = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (bus.done) begin
                dcyc = cyc;
                derr = bus.err;
                break;
            end
            tick();
        end
        if (dcyc < 0) begin
            n_checks++;
            $display("[TB] FAIL done_wait: got no done in %0d cycles, required a done pulse", bound);
        end
    endtask

    task automatic runVec(input vec_t v, output int lat);
        int   dcyc;
        logic derr;
        stall_addr = v.stall_addr;
        stall_left = v.stall_n;
        applyStimulus(v.preset);
        if (!v.exp_err) driveLock(v.lock_delay, v.glitch);
        waitDone(400, dcyc, derr);
        lat = dcyc - accept_cyc;
        if (dcyc >= 0) begin
            checkOutput("latency", 64'(lat), 64'(v.exp_lat));
            checkOutput("err_with_done", 64'(derr), 64'(v.exp_err));
            tick();
            checkOutput("done_one_cycle", 64'(bus.done), 64'd0);
            checkOutput("idle_after_fin", 64'(bus.req_ready), 64'd1);
        end
        checkOutput("writes_outstanding", 64'(exp_q.size()), 64'd0);
        pll_locked = 1'b0;
        tick(); tick(); tick();
    endtask

    initial begin
        int lat;
        int dcyc;
        int low_cnt;
        bit found;
        logic derr;

        exp_words[0] = '{32'h0001_0000, 32'h0002_0605, 32'h0002_0302, 32'd1055665304};
        exp_words[1] = '{32'h0001_0000, 32'h0000_0808, 32'h0000_0404, 32'h0000_0000};
        exp_words[2] = '{32'h0000_0101, 32'h0002_0C0B, 32'h0000_0505, 32'h8000_0000};
        exp_words[3] = '{32'h0001_0000, 32'h0000_0A0A, 32'h0002_0201, 32'h4000_0000};

        //                preset stall_addr  n  delay glitch err lat
        vecs[0] = '{0, 6'h3F,       0, 20, 1'b0, 1'b0, 41};
        vecs[1] = '{0, ADDR_M,      5, 20, 1'b0, 1'b0, 46};
        vecs[2] = '{1, 6'h3F,       0, 3,  1'b0, 1'b0, 24};
        vecs[3] = '{2, ADDR_K,      2, 5,  1'b0, 1'b0, 28};
        vecs[4] = '{3, ADDR_START,  4, 0,  1'b0, 1'b0, 25};
        vecs[5] = '{7, 6'h3F,       0, 0,  1'b0, 1'b1, 0};
        vecs[6] = '{4, 6'h3F,       0, 0,  1'b0, 1'b1, 0};
        vecs[7] = '{1, 6'h3F,       0, 2,  1'b1, 1'b0, 27};
        vec_after_rst = '{2, 6'h3F, 0, 1,  1'b0, 1'b0, 22};

        rst            = 1'b1;
        pll_locked     = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_preset = '0;
        tick(); tick(); tick();
        checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd1);
        checkOutput("rst_done", 64'(bus.done), 64'd0);
        checkOutput("rst_err", 64'(bus.err), 64'd0);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_write", 64'(bus.mgmt_write), 64'd0);
        checkOutput("rst_address", 64'(bus.mgmt_address), 64'd0);
        checkOutput("rst_writedata", 64'(bus.mgmt_writedata), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            $display("[TB] vector %0d preset %0d", i, vecs[i].preset);
            runVec(vecs[i], lat);
            if (i == 0) lat0 = lat;
            if (i == 1) lat1 = lat;
        end
        checkOutput("stall_latency_growth", 64'(lat1 - lat0), 64'd5);

        // Lock never arrives.
        $display("[TB] lock never asserts");
        stall_left = 0;
        applyStimulus(0);
`ifdef MF_PLL_RECFG_LOCK_TIMEOUT_EN
        waitDone(400, dcyc, derr);
        if (dcyc >= 0) begin
            checkOutput("timeout_latency", 64'(dcyc - accept_cyc), 64'(12 + TB_TIMEOUT));
            checkOutput("timeout_err", 64'(derr), 64'd1);
        end
`else
        low_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!bus.busy || bus.done) low_cnt++;
        end
        checkOutput("busy_hold_no_lock", 64'(low_cnt), 64'd0);
`endif
        checkOutput("writes_outstanding", 64'(exp_q.size()), 64'd0);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        exp_q.delete();
        tick();

        // Reset while the C0 write is pending, then a full replay.
        $display("[TB] reset during WR_C0");
        stall_left = 0;
        applyStimulus(2);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.busy && bus.mgmt_address == ADDR_C) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("reached_wr_c0", 64'(found), 64'd1);
        rst = 1'b1;
        tick();
        checkOutput("rst_mid_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_mid_ready", 64'(bus.req_ready), 64'd1);
        checkOutput("rst_mid_write", 64'(bus.mgmt_write), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        tick();
        runVec(vec_after_rst, lat);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
